// File: rtl/ysyx_23060072_fetch_ctrl.sv
// Fetch PC generation and single-entry IF/ID register.
// The PC flop drives the instruction ROM directly. The ROM word returned in
// the same cycle is captured together with its PC and offered to decode
// through a valid/ready handshake. Redirects from execute override
// everything else and flush the entry.
module ysyx_23060072_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en_i,
  output logic [31:0]       instr_addr_o,
  input  logic [DATA_W-1:0] inst_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              id_valid_o,
  output logic [31:0]       id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  output logic              fetch_err_o,
  output logic [31:0]       fetch_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  // Stage p0: fetch PC presented to the ROM.
  logic [31:0] pc_p0;

  // Stage p1: IF/ID entry handed to decode.
  logic              vld_p1;
  logic [31:0]       pc_p1;
  logic [DATA_W-1:0] inst_p1;

  logic        err_q;
  logic [31:0] cnt_q;

  logic fire;
  logic can_load;
  logic load;

  // Redirect targets are forced onto a word boundary; the low bits only
  // feed the sticky error flag.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

  function automatic logic misaligned(input logic [31:0] target);
    return target[1:0] != 2'b00;
  endfunction

  assign fire     = vld_p1 & id_ready_i;
  assign can_load = fetch_en_i & (~vld_p1 | id_ready_i);

  // Next-state and load decision; a redirect always suppresses the load.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_en_i) state_next = RUN;
      end
      RUN: begin
        if (!fetch_en_i) state_next = IDLE;
        if (can_load && !redirect_valid_i) load = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // PC, IF/ID entry, error flag and handoff counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0   <= RESET_PC;
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      inst_p1 <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Decode's acceptance counts even when a redirect flushes the entry.
      if (fire) cnt_q <= cnt_q + 32'd1;

      if (redirect_valid_i) begin
        pc_p0  <= align_pc(redirect_pc_i);
        vld_p1 <= 1'b0;
        if (misaligned(redirect_pc_i)) err_q <= 1'b1;
      end else if (load) begin
        vld_p1  <= 1'b1;
        pc_p1   <= pc_p0;
        inst_p1 <= inst_rdata_i;
        pc_p0   <= pc_p0 + PC_STEP;
      end else if (fire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign instr_addr_o = pc_p0;
  assign id_valid_o   = vld_p1;
  assign id_pc_o      = pc_p1;
  assign id_inst_o    = inst_p1;
  assign fetch_err_o  = err_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ysyx_23060072_fetch_ctrl.sv
// Bench for ysyx_23060072_fetch_ctrl: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_ysyx_23060072_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] instr_addr;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic        m_en_prev;
  logic [31:0] m_pc;
  logic        m_vld;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_err;
  logic [31:0] m_cnt;

  ysyx_23060072_fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_en_i       (fetch_en),
    .instr_addr_o     (instr_addr),
    .inst_rdata_i     (inst_rdata),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_pc_o          (id_pc),
    .id_inst_o        (id_inst),
    .id_ready_i       (id_ready),
    .fetch_err_o      (fetch_err),
    .fetch_cnt_o      (fetch_cnt)
  );

  always #5 clk = ~clk;

  // ROM contents: a scrambled function of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  assign inst_rdata = rom(instr_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge. The FSM is RUN exactly when fetch_en was
  // high at the previous edge (since reset), so only that bit is kept.
  task automatic model_edge();
    logic fire, can_load;
    if (!rst_n) begin
      m_pc = RESET_PC; m_vld = 0; m_id_pc = 0; m_id_inst = 0;
      m_err = 0; m_cnt = 0; m_en_prev = 0;
    end else begin
      fire     = m_vld & id_ready;
      can_load = fetch_en & (~m_vld | id_ready);
      if (fire) m_cnt = m_cnt + 1;
      if (redirect_valid) begin
        m_pc  = redirect_pc & 32'hFFFF_FFFC;
        m_vld = 0;
        if (redirect_pc % 4 != 0) m_err = 1;
      end else if (m_en_prev && can_load) begin
        m_id_pc   = m_pc;
        m_id_inst = rom(m_pc);
        m_pc      = m_pc + 4;
        m_vld     = 1;
      end else if (fire) begin
        m_vld = 0;
      end
      m_en_prev = fetch_en;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("id_valid",   {31'b0, id_valid},  {31'b0, m_vld});
    check("id_pc",      id_pc,              m_id_pc);
    check("id_inst",    id_inst,            m_id_inst);
    check("instr_addr", instr_addr,         m_pc);
    check("fetch_err",  {31'b0, fetch_err}, {31'b0, m_err});
    check("fetch_cnt",  fetch_cnt,          m_cnt);
  endtask

  initial begin
    m_en_prev = 0; m_pc = 0; m_vld = 0; m_id_pc = 0; m_id_inst = 0; m_err = 0; m_cnt = 0;
    rst_n = 0; fetch_en = 0; id_ready = 0; redirect_valid = 0; redirect_pc = 0;
    @(posedge clk); #1;

    // Reset state
    step();
    check("rst_addr", instr_addr, RESET_PC);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);

    // Streaming fetch with decode always ready
    rst_n = 1; fetch_en = 1; id_ready = 1;
    step();
    check("first_idle_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("first_pc", id_pc, 32'h8000_0000);
    check("first_inst", id_inst, rom(32'h8000_0000));
    check("first_next_addr", instr_addr, 32'h8000_0004);
    step();
    check("second_pc", id_pc, 32'h8000_0004);
    step();
    check("third_pc", id_pc, 32'h8000_0008);
    step();
    check("cnt_after_3", fetch_cnt, 32'd3);

    // Backpressure for four cycles
    id_ready = 0;
    repeat (4) step();
    check("stall_pc", id_pc, 32'h8000_000C);
    check("stall_addr", instr_addr, 32'h8000_0010);
    check("stall_cnt", fetch_cnt, 32'd3);
    id_ready = 1;
    step();
    check("release_pc", id_pc, 32'h8000_0010);

    // Redirect coinciding with a fire
    redirect_valid = 1; redirect_pc = 32'h8000_0040;
    step();
    check("redir_valid", {31'b0, id_valid}, 32'd0);
    check("redir_addr", instr_addr, 32'h8000_0040);
    check("redir_cnt", fetch_cnt, 32'd5);
    redirect_valid = 0;
    step();
    check("redir_entry_pc", id_pc, 32'h8000_0040);

    // Misaligned redirect, then the flag must stick
    redirect_valid = 1; redirect_pc = 32'h8000_0022;
    step();
    check("mis_addr", instr_addr, 32'h8000_0020);
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    redirect_valid = 0;
    repeat (10) step();

    // fetch_en dropped for three cycles, then resumed
    fetch_en = 0;
    repeat (3) step();
    fetch_en = 1;
    repeat (4) step();

    // Reset mid-stream together with a redirect
    rst_n = 0; redirect_valid = 1; redirect_pc = 32'h1234_5679;
    step();
    check("rst2_addr", instr_addr, RESET_PC);
    check("rst2_err", {31'b0, fetch_err}, 32'd0);
    rst_n = 1; redirect_valid = 0;
    repeat (3) step();

    // PC wrap across the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 0;
    repeat (3) step();
    check("wrap_addr", instr_addr, 32'h0000_0004);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
      rst_n          = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
